alu_sched: RTL
==============

// Module: alu_sched
// PURPOSE
//   Round-robin scheduler that shares the single 16-bit combinational ALU among NUM_REQ requesters.
//   Accepts one op at a time (A, B, 2-bit select) over a valid/ready handshake and drives the ALU.
//   Returns the registered result, tagged with the requester ID, over a valid/ready response port.
//   Sits between the requesting units and the ALU instance; the ALU itself stays combinational.
// PARAMETERS
//   NUM_REQ  4   number of requesters, 2..8
//   DATA_W   16  operand/result width; must match the ALU
//   ID_W     2   requester ID width, $clog2(NUM_REQ)
// PORTS
//   clk        in   1               single clock, rising edge
//   rst        in   1               synchronous, active-high reset
//   req_valid  in   NUM_REQ         per-requester op valid
//   req_ready  out  NUM_REQ         one-hot accept; at most one bit high per cycle
//   req_a      in   NUM_REQ*DATA_W  operand A; slice i belongs to requester i
//   req_b      in   NUM_REQ*DATA_W  operand B; slice i belongs to requester i
//   req_sel    in   NUM_REQ*2       op select; 00 pass A, 01 A+B, 10 A-B, 11 clear
//   alu_a      out  DATA_W          to ALU operand A
//   alu_b      out  DATA_W          to ALU operand B
//   alu_sel    out  2               to ALU select
//   alu_out    in   DATA_W          from ALU result
//   rsp_valid  out  1               response valid
//   rsp_ready  in   1               response accepted by consumer
//   rsp_id     out  ID_W            requester that issued the op
//   rsp_data   out  DATA_W          ALU result
//   busy       out  1               high in any state other than IDLE
//   rsp_flags  out  2               {carry/borrow, zero}; present only with ALU_SCHED_FLAGS_EN
// BEHAVIOUR
//   FSM states: IDLE -> EXEC -> RESP -> IDLE. Decisions are registered; the 3-cycle round trip is intentional.
//   IDLE: if any req_valid is high, the RR arbiter picks grant g and req_ready[g]=1 combinationally.
//     On that edge: latch req_a[g], req_b[g], req_sel[g] and g, then go to EXEC. No valid request: stay in IDLE.
//   EXEC: alu_sel = latched sel; rsp_data <= alu_out; go to RESP. req_ready = 0.
//   RESP: rsp_valid=1. rsp_id and rsp_data are held stable until rsp_ready=1.
//     On the handshake edge: go to IDLE and advance the RR pointer to g+1 mod NUM_REQ.
//   Latency: accept edge at cycle 0; rsp_valid is high from cycle 2. Max throughput is 1 op per 3 cycles.
//   alu_a and alu_b always show the latched operands. alu_sel is forced to 2'b00 outside EXEC.
//   RR priority: search starts at the pointer and wraps NUM_REQ-1 -> 0. The pointer moves only on a completed response.
//   Arithmetic: results wrap modulo 2^DATA_W. Clear returns 0. Pass returns A. B is ignored for pass and clear.
//   Backpressure: while rsp_ready=0 in RESP, nothing is accepted and all req_ready bits are 0.
//   Requester-side deassertion of req_valid before grant is legal. No op is lost once it has been accepted.
//   Reset, including mid-operation: state=IDLE, RR pointer=0 (req0 highest priority).
//     All outputs and latches are zeroed. Any in-flight op is discarded with no response.
// CONFIGURATION
//   ALU_SCHED_FLAGS_EN defined: the rsp_flags port exists and is captured in EXEC alongside rsp_data.
//     zero = (alu_out == 0).
//     carry = bit DATA_W of the zero-extended DATA_W+1 add for 01, or the borrow of the DATA_W+1 sub for 10.
//     carry = 0 for 00 and 11. Reset value is 2'b00.
//   ALU_SCHED_FLAGS_EN undefined: no rsp_flags port and no flag logic. All other behaviour is identical.
// STRUCTURE
//   Package alu_pkg:
//     alu_op_e = {ALU_PASS=2'b00, ALU_ADD=2'b01, ALU_SUB=2'b10, ALU_CLR=2'b11}
//     sched_state_e = {S_IDLE, S_EXEC, S_RESP}
//     localparam ALU_DATA_W=16
//   Sub-module rr_arbiter (NUM_REQ): inputs req vector and pointer; outputs one-hot grant, grant index, any_req.
//   The FSM, operand latches and flag logic stay in alu_sched.
// TESTING
//   1. req0 ADD 0x0003,0x0004, rsp_ready=1 -> req_ready[0] at cycle 0; rsp_valid cycle 2; data 0x0007, id 0.
//   2. req1 ADD 0xFFFF,0x0001 -> rsp_data 0x0000; flags build: rsp_flags=2'b11.
//   3. req2 SUB 0x0000,0x0001 -> 0xFFFF, flags 2'b10. req3 CLR 0x1234,0x5678 -> 0x0000, flags 2'b01.
//   4. All 4 req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0. alu_sel=00 outside EXEC.
//   5. rsp_ready=0 for 5 cycles in RESP -> rsp_valid/id/data stable; req_ready=0; no second accept.
//   6. rst pulsed while in EXEC -> no rsp_valid; state IDLE, busy=0; next grant goes to req0 despite the prior pointer.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU scheduler: op encoding, FSM state encoding and ALU width.
package alu_pkg;

  localparam int ALU_DATA_W = 16;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_CLR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps NUM_REQ-1 -> 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  function automatic int wrap_idx(input int base, input int offset);
    return (base + offset) % NUM_REQ;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!any_req && req[wrap_idx(int'(ptr), off)]) begin
        any_req   = 1'b1;
        grant[wrap_idx(int'(ptr), off)] = 1'b1;
        grant_idx = ID_W'(wrap_idx(int'(ptr), off));
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ requesters.
// Optional ALU_SCHED_FLAGS_EN adds the registered {carry/borrow, zero} response flags.
module alu_sched
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]  req_sel,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [1:0]            alu_sel,
  input  logic [DATA_W-1:0]     alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy
`ifdef ALU_SCHED_FLAGS_EN
  ,
  output logic [1:0]            rsp_flags
`endif
);

  sched_state_e         state;
  logic [ID_W-1:0]      ptr;
  logic [DATA_W-1:0]    a_q;
  logic [DATA_W-1:0]    b_q;
  alu_op_e              sel_q;
  logic [ID_W-1:0]      id_q;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign req_ready = (state == S_IDLE) ? grant : '0;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  // The ALU only sees the real op during EXEC; elsewhere it idles on pass.
  assign alu_sel   = (state == S_EXEC) ? sel_q : ALU_PASS;
  assign rsp_id    = id_q;
  assign busy      = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= ALU_PASS;
      id_q      <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            a_q   <= req_a[int'(grant_idx)*DATA_W +: DATA_W];
            b_q   <= req_b[int'(grant_idx)*DATA_W +: DATA_W];
            sel_q <= alu_op_e'(req_sel[int'(grant_idx)*2 +: 2]);
            id_q  <= grant_idx;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= alu_out;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SCHED_FLAGS_EN
  logic [DATA_W:0] wide_res;
  logic            carry_nxt;

  // Carry/borrow comes from a DATA_W+1 recompute on the latched operands, not from the ALU.
  always_comb begin
    wide_res  = '0;
    carry_nxt = 1'b0;
    case (sel_q)
      ALU_ADD: begin
        wide_res  = {1'b0, a_q} + {1'b0, b_q};
        carry_nxt = wide_res[DATA_W];
      end
      ALU_SUB: begin
        wide_res  = {1'b0, a_q} - {1'b0, b_q};
        carry_nxt = wide_res[DATA_W];
      end
      default: carry_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_flags <= 2'b00;
    end else if (state == S_EXEC) begin
      rsp_flags <= {carry_nxt, (alu_out == '0)};
    end
  end
`endif

endmodule
